// File: rtl/id_ex_decode_stage.sv
// Instruction decode and ID/EX pipeline register for the 5-stage RV32I core.
// Decodes R-type/lw/sw/beq into the EX control bundle and inserts load-use bubbles.
module id_ex_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_id,
    input  logic        valid_id,
    input  logic        flush,
    input  logic        stall_ex,
    output logic        hazard_stall,
    output logic        valid_ex,
    output logic        illegal_ex,
    output logic [1:0]  alu_op_ex,
    output logic [2:0]  funct3_ex,
    output logic [6:0]  funct7_ex,
    output logic        alu_src_ex,
    output logic        reg_write_ex,
    output logic        mem_read_ex,
    output logic        mem_write_ex,
    output logic        mem_to_reg_ex,
    output logic        branch_ex,
    output logic [4:0]  rs1_ex,
    output logic [4:0]  rs2_ex,
    output logic [4:0]  rd_ex,
    output logic [31:0] imm_ex
);

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [1:0]  alu_op;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } ex_bundle_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    ex_bundle_t dec;
    ex_bundle_t ex_q;
    logic [6:0] opcode;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       uses_rs2;

    assign opcode = instr_id[6:0];
    assign rs1_id = instr_id[19:15];
    assign rs2_id = instr_id[24:20];

    // An all-zero bundle is a bubble, so an invalid ID slot decodes straight to one.
    always_comb begin
        dec = '0;
        if (valid_id) begin
            dec.valid  = 1'b1;
            dec.funct3 = instr_id[14:12];
            dec.funct7 = instr_id[31:25];
            dec.rs1    = rs1_id;
            dec.rs2    = rs2_id;
            dec.rd     = instr_id[11:7];
            case (opcode)
                OP_RTYPE: begin
                    dec.alu_op    = 2'd2;
                    dec.reg_write = 1'b1;
                end
                OP_LOAD: begin
                    dec.alu_op     = 2'd0;
                    dec.alu_src    = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.mem_read   = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.imm        = {{20{instr_id[31]}}, instr_id[31:20]};
                end
                OP_STORE: begin
                    dec.alu_op    = 2'd0;
                    dec.alu_src   = 1'b1;
                    dec.mem_write = 1'b1;
                    dec.imm       = {{20{instr_id[31]}}, instr_id[31:25], instr_id[11:7]};
                end
                OP_BRANCH: begin
                    dec.alu_op = 2'd1;
                    dec.branch = 1'b1;
                    dec.imm    = {{19{instr_id[31]}}, instr_id[31], instr_id[7],
                                  instr_id[30:25], instr_id[11:8], 1'b0};
                end
                default: begin
                    dec.illegal = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        uses_rs2 = 1'b0;
        if ((opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH)) begin
            uses_rs2 = 1'b1;
        end
    end

    // A taken branch kills the ID instruction, so it can never be a load consumer.
    assign hazard_stall = valid_id & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0)
                        & ((ex_q.rd == rs1_id) | (uses_rs2 & (ex_q.rd == rs2_id)))
                        & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (!stall_ex) begin
            if (hazard_stall) begin
                ex_q <= '0;
            end else begin
                ex_q <= dec;
            end
        end
    end

    assign valid_ex      = ex_q.valid;
    assign illegal_ex    = ex_q.illegal;
    assign alu_op_ex     = ex_q.alu_op;
    assign funct3_ex     = ex_q.funct3;
    assign funct7_ex     = ex_q.funct7;
    assign alu_src_ex    = ex_q.alu_src;
    assign reg_write_ex  = ex_q.reg_write;
    assign mem_read_ex   = ex_q.mem_read;
    assign mem_write_ex  = ex_q.mem_write;
    assign mem_to_reg_ex = ex_q.mem_to_reg;
    assign branch_ex     = ex_q.branch;
    assign rs1_ex        = ex_q.rs1;
    assign rs2_ex        = ex_q.rs2;
    assign rd_ex         = ex_q.rd;
    assign imm_ex        = ex_q.imm;

endmodule
